// File: rtl/cache_fill_arbiter_if.sv
// Cache-side and memory-side signal bundle for cache_fill_arbiter.
// The arbiter uses the slave modport; the caches/memory environment uses master.
interface cache_fill_arbiter_if #(
    parameter int ADDR_W         = 16,
    parameter int DATA_W         = 16,
    parameter int WORDS_PER_LINE = 8
);
    localparam int OFF_W = $clog2(WORDS_PER_LINE);

    logic              i_miss;
    logic [ADDR_W-1:0] i_miss_addr;
    logic              d_miss;
    logic [ADDR_W-1:0] d_miss_addr;
    logic              d_wr_req;
    logic [ADDR_W-1:0] d_wr_addr;
    logic [DATA_W-1:0] d_wr_data;

    logic              mem_en;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_valid;

    logic [DATA_W-1:0] fill_data;
    logic [OFF_W-1:0]  fill_word;
    logic [ADDR_W-1:0] fill_addr;
    logic              fill_we_i;
    logic              fill_we_d;
    logic              tag_we_i;
    logic              tag_we_d;
    logic              d_wr_ack;
    logic              busy;
    logic              i_stall;
    logic              d_stall;

    modport slave (
        input  i_miss, i_miss_addr, d_miss, d_miss_addr,
        input  d_wr_req, d_wr_addr, d_wr_data,
        input  mem_rdata, mem_valid,
        output mem_en, mem_wr, mem_addr, mem_wdata,
        output fill_data, fill_word, fill_addr, fill_we_i, fill_we_d,
        output tag_we_i, tag_we_d, d_wr_ack, busy, i_stall, d_stall
    );

    modport master (
        output i_miss, i_miss_addr, d_miss, d_miss_addr,
        output d_wr_req, d_wr_addr, d_wr_data,
        output mem_rdata, mem_valid,
        input  mem_en, mem_wr, mem_addr, mem_wdata,
        input  fill_data, fill_word, fill_addr, fill_we_i, fill_we_d,
        input  tag_we_i, tag_we_d, d_wr_ack, busy, i_stall, d_stall
    );
endinterface

// File: rtl/cache_fill_arbiter.sv
// Arbitrates I/D line fills and D write-through stores onto one pipelined memory;
// streams returned words into the granted cache, then pulses its tag write.
module cache_fill_arbiter #(
    parameter int ADDR_W         = 16,
    parameter int DATA_W         = 16,
    parameter int WORDS_PER_LINE = 8,
    parameter int ARB_MODE       = 0
) (
    input logic                  clk,
    input logic                  rst_n,
    cache_fill_arbiter_if.slave  bus
);
    localparam int unsigned OFF_W = $clog2(WORDS_PER_LINE);
    localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS_PER_LINE - 1);
    localparam logic [ADDR_W-1:0] BASE_MASK =
        {{(ADDR_W - OFF_W - 1){1'b1}}, {(OFF_W + 1){1'b0}}};

    typedef enum logic [1:0] {IDLE, FILL, TAG, WRITE} state_t;
    typedef enum logic {OWN_I, OWN_D} owner_t;

    state_t            state_q;
    owner_t            owner_q;
    owner_t            last_grant_q;
    logic [ADDR_W-1:0] line_base_q;
    logic [OFF_W-1:0]  issue_q;
    logic [OFF_W-1:0]  rcv_q;
    logic              mem_en_q;
    logic              mem_wr_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [DATA_W-1:0] fill_data_q;
    logic [OFF_W-1:0]  fill_word_q;
    logic              fill_we_i_q;
    logic              fill_we_d_q;
    logic              tag_we_i_q;
    logic              tag_we_d_q;
    logic              d_wr_ack_q;

    owner_t            grant_d;
    logic [ADDR_W-1:0] line_base_d;
    logic [OFF_W-1:0]  issue_nxt;
    logic              last_strobe;

    always_comb begin
        grant_d = OWN_I;
        if (bus.i_miss && bus.d_miss) begin
            grant_d = (ARB_MODE == 1 && last_grant_q == OWN_I) ? OWN_D : OWN_I;
        end else if (bus.d_miss) begin
            grant_d = OWN_D;
        end
        line_base_d = ((grant_d == OWN_D) ? bus.d_miss_addr : bus.i_miss_addr) & BASE_MASK;
        issue_nxt   = issue_q + OFF_W'(1);
        last_strobe = (fill_we_i_q || fill_we_d_q) && (fill_word_q == LAST_WORD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            owner_q      <= OWN_I;
            last_grant_q <= OWN_D;
            line_base_q  <= '0;
            issue_q      <= '0;
            rcv_q        <= '0;
            mem_en_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            fill_data_q  <= '0;
            fill_word_q  <= '0;
            fill_we_i_q  <= 1'b0;
            fill_we_d_q  <= 1'b0;
            tag_we_i_q   <= 1'b0;
            tag_we_d_q   <= 1'b0;
            d_wr_ack_q   <= 1'b0;
        end else begin
            fill_we_i_q <= 1'b0;
            fill_we_d_q <= 1'b0;
            tag_we_i_q  <= 1'b0;
            tag_we_d_q  <= 1'b0;
            d_wr_ack_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.i_miss || bus.d_miss) begin
                        state_q      <= FILL;
                        owner_q      <= grant_d;
                        last_grant_q <= grant_d;
                        line_base_q  <= line_base_d;
                        issue_q      <= '0;
                        rcv_q        <= '0;
                        mem_en_q     <= 1'b1;
                        mem_wr_q     <= 1'b0;
                        // word 0 address equals the line base (offset bits already clear)
                        mem_addr_q   <= line_base_d;
                    end else if (bus.d_wr_req) begin
                        state_q     <= WRITE;
                        mem_en_q    <= 1'b1;
                        mem_wr_q    <= 1'b1;
                        mem_addr_q  <= bus.d_wr_addr;
                        mem_wdata_q <= bus.d_wr_data;
                        d_wr_ack_q  <= 1'b1;
                    end
                end
                FILL: begin
                    if (mem_en_q) begin
                        if (issue_q == LAST_WORD) begin
                            mem_en_q <= 1'b0;
                        end else begin
                            issue_q    <= issue_nxt;
                            mem_addr_q <= {line_base_q[ADDR_W-1:OFF_W+1], issue_nxt, 1'b0};
                        end
                    end
                    if (bus.mem_valid) begin
                        fill_data_q <= bus.mem_rdata;
                        fill_word_q <= rcv_q;
                        rcv_q       <= rcv_q + OFF_W'(1);
                        fill_we_i_q <= (owner_q == OWN_I);
                        fill_we_d_q <= (owner_q == OWN_D);
                    end
                    if (last_strobe) begin
                        state_q    <= TAG;
                        tag_we_i_q <= (owner_q == OWN_I);
                        tag_we_d_q <= (owner_q == OWN_D);
                    end
                end
                TAG: begin
                    state_q <= IDLE;
                end
                WRITE: begin
                    state_q  <= IDLE;
                    mem_en_q <= 1'b0;
                    mem_wr_q <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_en    = mem_en_q;
    assign bus.mem_wr    = mem_wr_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.fill_data = fill_data_q;
    assign bus.fill_word = fill_word_q;
    assign bus.fill_addr = line_base_q;
    assign bus.fill_we_i = fill_we_i_q;
    assign bus.fill_we_d = fill_we_d_q;
    assign bus.tag_we_i  = tag_we_i_q;
    assign bus.tag_we_d  = tag_we_d_q;
    assign bus.d_wr_ack  = d_wr_ack_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.i_stall   = bus.i_miss
                         | ((state_q != IDLE) && owner_q == OWN_I && state_q != WRITE);
    assign bus.d_stall   = bus.d_miss | (bus.d_wr_req & ~d_wr_ack_q)
                         | ((state_q != IDLE) && owner_q == OWN_D && state_q != WRITE);
endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Directed bench: instance A (fixed priority, 8-word lines, latency 4) and
// instance B (round-robin, 4-word lines, latency 2), each with a pipelined memory model.
module tb_cache_fill_arbiter;
    localparam int LAT_A = 4;
    localparam int LAT_B = 2;

    logic clk;
    logic rst_n;

    cache_fill_arbiter_if #(.ADDR_W(16), .DATA_W(16), .WORDS_PER_LINE(8)) ifa ();
    cache_fill_arbiter_if #(.ADDR_W(16), .DATA_W(16), .WORDS_PER_LINE(4)) ifb ();

    cache_fill_arbiter #(.ADDR_W(16), .DATA_W(16), .WORDS_PER_LINE(8), .ARB_MODE(0))
        u_dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    cache_fill_arbiter #(.ADDR_W(16), .DATA_W(16), .WORDS_PER_LINE(4), .ARB_MODE(1))
        u_dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return a ^ 16'h5A5A;
    endfunction

    // Fixed-latency memories: a read issued in cycle c returns valid in cycle c+LAT.
    logic [3:0]  va = '0;
    logic [3:0]  vb = '0;
    logic [15:0] da [4];
    logic [15:0] db [4];
    always @(posedge clk) begin
        va    <= {va[2:0], ifa.mem_en & ~ifa.mem_wr};
        vb    <= {vb[2:0], ifb.mem_en & ~ifb.mem_wr};
        da[0] <= mem_word(ifa.mem_addr);
        db[0] <= mem_word(ifb.mem_addr);
        for (int i = 1; i < 4; i++) begin
            da[i] <= da[i-1];
            db[i] <= db[i-1];
        end
    end
    assign ifa.mem_valid = va[LAT_A-1];
    assign ifa.mem_rdata = da[LAT_A-1];
    assign ifb.mem_valid = vb[LAT_B-1];
    assign ifb.mem_rdata = db[LAT_B-1];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    int strobes, ni, nd, overlap, d_before_i, first_tag, tag_c, ack_c, wr_early;
    int ntags, fw, iss;
    bit i_done, d_done, re_i, re_d;
    int order [4];
    logic [15:0] base, first_addr;

    initial begin
        rst_n = 1'b0;
        ifa.i_miss = 0; ifa.i_miss_addr = '0; ifa.d_miss = 0; ifa.d_miss_addr = '0;
        ifa.d_wr_req = 0; ifa.d_wr_addr = '0; ifa.d_wr_data = '0;
        ifb.i_miss = 0; ifb.i_miss_addr = '0; ifb.d_miss = 0; ifb.d_miss_addr = '0;
        ifb.d_wr_req = 0; ifb.d_wr_addr = '0; ifb.d_wr_data = '0;
        repeat (2) @(negedge clk);
        check("rst_mem_en", 32'(ifa.mem_en), 0);
        check("rst_fill_we", 32'({ifa.fill_we_i, ifa.fill_we_d, ifa.tag_we_i, ifa.tag_we_d}), 0);
        check("rst_busy_ack", 32'({ifa.busy, ifa.d_wr_ack, ifb.busy}), 0);
        check("rst_stalls", 32'({ifa.i_stall, ifa.d_stall}), 0);
        check("rst_fill_addr", 32'(ifa.fill_addr), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset in the middle of an I fill.
        ifa.i_miss = 1; ifa.i_miss_addr = 16'h0000;
        strobes = 0;
        for (int c = 0; c < 20 && strobes < 3; c++) begin
            @(negedge clk);
            if (ifa.fill_we_i) strobes++;
        end
        check("rstfill_third_strobe", 32'(strobes), 3);
        check("rstfill_word", 32'(ifa.fill_word), 2);
        rst_n = 1'b0; ifa.i_miss = 0;
        #1;
        check("rstfill_mem_en", 32'(ifa.mem_en), 0);
        check("rstfill_strobe", 32'(ifa.fill_we_i), 0);
        check("rstfill_busy", 32'(ifa.busy), 0);
        check("rstfill_word0", 32'(ifa.fill_word), 0);
        check("rstfill_data0", 32'(ifa.fill_data), 0);
        check("rstfill_istall", 32'(ifa.i_stall), 0);
        @(negedge clk); rst_n = 1'b1;
        strobes = 0;
        repeat (8) begin
            @(negedge clk);
            if (ifa.fill_we_i | ifa.fill_we_d | ifa.tag_we_i | ifa.tag_we_d) strobes++;
        end
        check("rstfill_no_strobes", 32'(strobes), 0);
        ifa.i_miss = 1; ifa.i_miss_addr = 16'h0024;
        ifa.d_miss = 1; ifa.d_miss_addr = 16'h0530;
        @(negedge clk);
        check("rstfill_regrant_busy", 32'(ifa.busy), 1);
        check("rstfill_regrant_addr", 32'(ifa.mem_addr), 32'h0020);
        check("rstfill_regrant_i", 32'(ifa.fill_addr), 32'h0020);
        rst_n = 1'b0; ifa.i_miss = 0; ifa.d_miss = 0;
        @(negedge clk); rst_n = 1'b1;
        repeat (6) @(negedge clk);

        // Single I miss at 0x0046, W=8, L=4.
        ifa.i_miss = 1; ifa.i_miss_addr = 16'h0046;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            check("imiss_mem_en", 32'(ifa.mem_en), 32'(c >= 1 && c <= 8));
            if (c >= 1 && c <= 8) begin
                check("imiss_mem_addr", 32'(ifa.mem_addr), 32'(16'h0040 + 16'(2 * (c - 1))));
                check("imiss_mem_wr", 32'(ifa.mem_wr), 0);
            end
            check("imiss_fill_we_i", 32'(ifa.fill_we_i), 32'(c >= 6 && c <= 13));
            check("imiss_fill_we_d", 32'(ifa.fill_we_d), 0);
            if (c >= 6 && c <= 13) begin
                check("imiss_fill_word", 32'(ifa.fill_word), 32'(c - 6));
                check("imiss_fill_data", 32'(ifa.fill_data),
                      32'(mem_word(16'h0040 + 16'(2 * (c - 6)))));
                check("imiss_fill_addr", 32'(ifa.fill_addr), 32'h0040);
            end
            check("imiss_tag_we_i", 32'(ifa.tag_we_i), 32'(c == 14));
            check("imiss_i_stall", 32'(ifa.i_stall), 32'(c <= 14));
            check("imiss_d_stall", 32'(ifa.d_stall), 0);
            if (c == 14) ifa.i_miss = 0;
            if (c == 15) check("imiss_idle", 32'(ifa.busy), 0);
        end

        // Simultaneous I and D misses under fixed priority.
        ifa.i_miss = 1; ifa.i_miss_addr = 16'h0200;
        ifa.d_miss = 1; ifa.d_miss_addr = 16'h0312;
        ni = 0; nd = 0; overlap = 0; d_before_i = 0; first_tag = -1; i_done = 0; d_done = 0;
        for (int c = 0; c < 80 && !(i_done && d_done); c++) begin
            @(negedge clk);
            if (ifa.fill_we_i && ifa.fill_we_d) overlap++;
            if (ifa.fill_we_i) ni++;
            if (ifa.fill_we_d) begin
                nd++;
                if (!i_done) d_before_i++;
                if (nd == 1) check("both_d_fill_addr", 32'(ifa.fill_addr), 32'h0310);
            end
            if (ifa.tag_we_i) begin i_done = 1; ifa.i_miss = 0; if (first_tag < 0) first_tag = 0; end
            if (ifa.tag_we_d) begin d_done = 1; ifa.d_miss = 0; if (first_tag < 0) first_tag = 1; end
        end
        check("both_completed", 32'({i_done, d_done}), 32'b11);
        check("both_first_is_i", 32'(first_tag), 0);
        check("both_i_strobes", 32'(ni), 8);
        check("both_d_strobes", 32'(nd), 8);
        check("both_overlap", 32'(overlap), 0);
        check("both_d_before_i", 32'(d_before_i), 0);
        @(negedge clk);

        // Store while idle.
        ifa.d_wr_req = 1; ifa.d_wr_addr = 16'h0100; ifa.d_wr_data = 16'hBEEF;
        #1;
        check("st_stall_pre", 32'(ifa.d_stall), 1);
        @(negedge clk);
        check("st_mem_en", 32'(ifa.mem_en), 1);
        check("st_mem_wr", 32'(ifa.mem_wr), 1);
        check("st_mem_addr", 32'(ifa.mem_addr), 32'h0100);
        check("st_mem_wdata", 32'(ifa.mem_wdata), 32'hBEEF);
        check("st_ack", 32'(ifa.d_wr_ack), 1);
        ifa.d_wr_req = 0;
        @(negedge clk);
        check("st_ack_pulse", 32'(ifa.d_wr_ack), 0);
        check("st_mem_en_off", 32'(ifa.mem_en), 0);
        check("st_d_stall_after", 32'(ifa.d_stall), 0);
        check("st_idle", 32'(ifa.busy), 0);

        // Store raised during an I fill waits for the fill to finish.
        ifa.i_miss = 1; ifa.i_miss_addr = 16'h0080;
        tag_c = -1; ack_c = -1; wr_early = 0;
        for (int c = 1; c <= 40 && ack_c < 0; c++) begin
            @(negedge clk);
            if (c == 1) begin
                ifa.d_wr_req = 1; ifa.d_wr_addr = 16'h0120; ifa.d_wr_data = 16'h1234;
            end
            if (c == 5) check("stfill_d_stall", 32'(ifa.d_stall), 1);
            if (ifa.mem_wr && tag_c < 0) wr_early++;
            if (ifa.tag_we_i) begin tag_c = c; ifa.i_miss = 0; end
            if (ifa.d_wr_ack) begin
                ack_c = c;
                check("stfill_addr", 32'(ifa.mem_addr), 32'h0120);
                check("stfill_wdata", 32'(ifa.mem_wdata), 32'h1234);
                ifa.d_wr_req = 0;
            end
        end
        check("stfill_tag_cycle", 32'(tag_c), 14);
        check("stfill_ack_cycle", 32'(ack_c), 16);
        check("stfill_no_early_wr", 32'(wr_early), 0);
        @(negedge clk);

        // Round-robin, 4-word lines: held misses re-raised after each fill.
        ifb.i_miss = 1; ifb.i_miss_addr = 16'h0047;
        ifb.d_miss = 1; ifb.d_miss_addr = 16'h012D;
        ntags = 0; fw = 0; iss = 0; re_i = 0; re_d = 0; first_addr = '0;
        for (int c = 0; c < 200 && ntags < 4; c++) begin
            @(negedge clk);
            if (re_i) begin ifb.i_miss = 1; re_i = 0; end
            if (re_d) begin ifb.d_miss = 1; re_d = 0; end
            if (ifb.mem_en) begin
                if (iss == 0) first_addr = ifb.mem_addr;
                iss++;
            end
            if (ifb.fill_we_i | ifb.fill_we_d) begin
                base = ifb.fill_we_d ? 16'h0128 : 16'h0040;
                check("rr_fill_word", 32'(ifb.fill_word), 32'(fw));
                check("rr_fill_addr", 32'(ifb.fill_addr), 32'(base));
                check("rr_fill_data", 32'(ifb.fill_data), 32'(mem_word(base + 16'(2 * fw))));
                fw++;
            end
            if (ifb.tag_we_i | ifb.tag_we_d) begin
                base = ifb.tag_we_d ? 16'h0128 : 16'h0040;
                order[ntags] = int'(ifb.tag_we_d);
                ntags++;
                check("rr_strobes", 32'(fw), 4);
                check("rr_issues", 32'(iss), 4);
                check("rr_first_issue", 32'(first_addr), 32'(base));
                fw = 0; iss = 0;
                if (ifb.tag_we_i) begin ifb.i_miss = 0; re_i = 1; end
                else begin ifb.d_miss = 0; re_d = 1; end
            end
        end
        ifb.i_miss = 0; ifb.d_miss = 0;
        check("rr_grant_count", 32'(ntags), 4);
        for (int g = 0; g < 4; g++) begin
            if (g < ntags) check("rr_grant_order", 32'(order[g]), 32'(g % 2));
        end
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/cache_fill_arbiter.md
Name: cache_fill_arbiter

Overview:
- Parametrised successor to the phase-3 single-miss fill path. It arbitrates line-fill requests from the instruction and data caches, plus write-through stores from the data cache, onto one shared multi-cycle memory.
- It issues pipelined word reads, streams returned words into the granted cache with a word index, then pulses that cache's tag write.
- It sits between the I/D cache arrays and memory4c-style main memory, and drives the fetch and memory stall signals.

Parameters:
- ADDR_W, 16: byte address width.
- DATA_W, 16: word width; one word is 2 bytes.
- WORDS_PER_LINE, 8: words per cache line; power of two, at least 2. OFF_W = $clog2(WORDS_PER_LINE).
- ARB_MODE, 0: 0 = fixed instruction priority; 1 = round-robin between I and D misses.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- i_miss  in  1  instruction cache miss, held until the line is resident.
- i_miss_addr  in  ADDR_W  instruction miss byte address.
- d_miss  in  1  data cache miss, held until the line is resident.
- d_miss_addr  in  ADDR_W  data miss byte address.
- d_wr_req  in  1  write-through store request, held until d_wr_ack.
- d_wr_addr  in  ADDR_W  store byte address.
- d_wr_data  in  DATA_W  store data.
- mem_en  out  1  memory access enable.
- mem_wr  out  1  memory write (1) / read (0).
- mem_addr  out  ADDR_W  memory byte address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.
- mem_valid  in  1  mem_rdata valid; returns in issue order at a fixed latency L of 1 or more.
- fill_data  out  DATA_W  word to write into the cache (registered copy of mem_rdata).
- fill_word  out  OFF_W  word index within the line.
- fill_addr  out  ADDR_W  line base address of the active fill.
- fill_we_i  out  1  instruction cache data write strobe.
- fill_we_d  out  1  data cache data write strobe.
- tag_we_i  out  1  instruction cache tag/valid write, 1-cycle pulse.
- tag_we_d  out  1  data cache tag/valid write, 1-cycle pulse.
- d_wr_ack  out  1  store accepted and written, 1-cycle pulse.
- busy  out  1  state is not IDLE.
- i_stall  out  1  stall the fetch stage.
- d_stall  out  1  stall the memory stage.

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; issue and receive counters 0; owner=I; last_grant=D, so the first round-robin grant goes to I.
- Reset mid-fill aborts immediately. mem_valid arriving in IDLE is ignored; no fill or tag strobe is produced.
- States: IDLE, FILL, TAG, WRITE.
- IDLE grant order (evaluated each cycle, registered at the edge):
  - If any miss is pending:
    - ARB_MODE 0: i_miss wins over d_miss.
    - ARB_MODE 1: if both are pending, the side other than last_grant wins, and last_grant updates.
    - Latch owner and line_base = miss_addr with bits [OFF_W:0] cleared. Go to FILL.
  - Else if d_wr_req: latch d_wr_addr and d_wr_data, go to WRITE.
  - Stores have lowest priority.
- FILL, issue side:
  - Issue counter k runs 0..WORDS_PER_LINE-1, one per cycle.
  - mem_en=1, mem_wr=0, mem_addr = {line_base[ADDR_W-1:OFF_W+1], k, 1'b0}.
  - mem_en drops after the last issue.
- FILL, receive side:
  - Each mem_valid registers mem_rdata into fill_data.
  - Next cycle: fill_word = receive count; pulse fill_we_i or fill_we_d per owner; fill_addr = line_base.
  - Receive counter increments; there is exactly one strobe per valid.
- FILL exit: the cycle after the last word's strobe, go to TAG.
- TAG: pulse tag_we_i or tag_we_d for 1 cycle, then IDLE. The cache's miss deasserts as a hit, and the next request can be granted in the following IDLE cycle.
- WRITE: one cycle with mem_en=1, mem_wr=1, latched address and data, d_wr_ack=1. Then IDLE.
- Latency, grant edge E0, memory latency L, W = WORDS_PER_LINE:
  - Issues occur in cycles 1..W.
  - The strobe for word k occurs in cycle k+2+L.
  - tag_we occurs in cycle W+L+2.
- Address stability: request addresses are sampled only at grant; changes during FILL are ignored.
- Stalls (combinational):
  - i_stall = i_miss | (busy & owner==I & state!=WRITE).
  - d_stall = d_miss | (d_wr_req & !d_wr_ack) | (busy & owner==D & state!=WRITE).
- Simultaneous events:
  - An I miss arriving during a D fill waits; it is granted at the first IDLE cycle after TAG.
  - A store arriving during a fill waits; it is accepted only when no miss is pending (ARB_MODE 0).
  - mem_valid outside FILL is ignored.

Test Plan:
- Reset mid-fill: reset with rst_n=0 held 2 cycles, then release; start an I fill at 0x0000 and drop rst_n after the 3rd strobe -> all outputs 0 immediately; no further fill or tag strobes; the next grant is I.
- I miss at 0x0046, W=8, L=4 -> mem_addr 0x0040, 0x0042 ... 0x004E in cycles 1..8. fill_we_i with fill_word 0..7 in cycles 6..13, fill_data = memory contents. tag_we_i in cycle 14. i_stall high throughout; d_stall low.
- i_miss and d_miss raised in the same cycle, ARB_MODE 0 -> I filled first, then D. No overlap of fill_we_i and fill_we_d.
- ARB_MODE 1, both misses held continuously and re-raised after each fill -> grants alternate I, D, I, D.
- d_wr_req 0x0100 with data 0xBEEF while idle -> next cycle mem_en=1, mem_wr=1, addr 0x0100, wdata 0xBEEF, d_wr_ack=1. d_stall is low in the following cycle.
- d_wr_req raised during an I fill -> no mem_wr during the fill; the store completes in the cycle after TAG+1.
- WORDS_PER_LINE=4 build -> issues stop after 4 words; fill_word wraps 0..3; line_base clears bits [2:0].
